// File: rtl/batt_mon.sv
`default_nettype none
// ============================================================================
// Module   : batt_mon
// Purpose  : Block-averaged, hysteretic battery-low monitor for the piezo
//            driver, with an optional sticky critical flag (BATT_MON_CRIT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module batt_mon #(
   parameter int          AVG_LOG2   = 3,
   parameter logic [11:0] LOW_THRES  = 12'h800,
   parameter logic [11:0] HYST       = 12'h040,
   parameter logic [11:0] CRIT_THRES = 12'h700,
   parameter int          DWELL      = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        batt_vld,
   input  logic [11:0] batt,
   output logic [11:0] batt_avg,
   output logic        avg_rdy,
   output logic        batt_low,
   output logic        batt_crit
);

   localparam int          c_acc_w    = 12 + AVG_LOG2;
   localparam logic [3:0]  c_dwell    = 4'(DWELL);
   // 13 bits so LOW_THRES+HYST cannot wrap past full scale
   localparam logic [12:0] c_exit_thr = {1'b0, LOW_THRES} + {1'b0, HYST};

   if (AVG_LOG2 < 1 || AVG_LOG2 > 5) begin : g_bad_avg
      $error("batt_mon: AVG_LOG2 out of range");
   end
   if (DWELL < 1 || DWELL > 15) begin : g_bad_dwell
      $error("batt_mon: DWELL out of range");
   end
   if (CRIT_THRES >= LOW_THRES) begin : g_bad_crit
      $error("batt_mon: CRIT_THRES must be below LOW_THRES");
   end

   // ------------------------------------------------------------------------
   // Block averager
   // ------------------------------------------------------------------------
   logic [c_acc_w-1:0]  r_acc;
   logic [AVG_LOG2-1:0] r_cnt;
   logic [c_acc_w-1:0]  w_sum;

   assign w_sum = r_acc + {{AVG_LOG2{1'b0}}, batt};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_cnt    <= '0;
         batt_avg <= 12'hFFF;
         avg_rdy  <= 1'b0;
      end else begin
         avg_rdy <= 1'b0;
         if (batt_vld) begin
            if (&r_cnt) begin
               batt_avg <= w_sum[AVG_LOG2 +: 12];
               avg_rdy  <= 1'b1;
               r_acc    <= '0;
               r_cnt    <= '0;
            end else begin
               r_acc <= w_sum;
               r_cnt <= r_cnt + AVG_LOG2'(1);
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Hysteretic OK/LOW(/CRIT) state machine, stepped once per average
   // ------------------------------------------------------------------------
`ifdef BATT_MON_CRIT_EN
   typedef enum logic [1:0] {
      ST_OK   = 2'd0,
      ST_LOW  = 2'd1,
      ST_CRIT = 2'd2
   } state_t;
`else
   typedef enum logic [0:0] {
      ST_OK  = 1'b0,
      ST_LOW = 1'b1
   } state_t;
`endif

   state_t     r_state;
   logic [3:0] r_low_cnt;
   logic       w_below_low;
   logic       w_above_exit;
   logic       w_low_hit;

   assign w_below_low  = batt_avg < LOW_THRES;
   assign w_above_exit = {1'b0, batt_avg} >= c_exit_thr;
   assign w_low_hit    = (r_low_cnt + 4'd1) == c_dwell;

`ifdef BATT_MON_CRIT_EN
   logic [3:0] r_crit_cnt;
   logic       w_below_crit;
   logic       w_crit_hit;

   assign w_below_crit = batt_avg < CRIT_THRES;
   assign w_crit_hit   = (r_crit_cnt + 4'd1) == c_dwell;
`else
   assign batt_crit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_OK;
         r_low_cnt  <= 4'd0;
         batt_low   <= 1'b0;
`ifdef BATT_MON_CRIT_EN
         r_crit_cnt <= 4'd0;
         batt_crit  <= 1'b0;
`endif
      end else if (avg_rdy) begin
         case (r_state)
            ST_OK: begin
               if (!w_below_low) begin
                  r_low_cnt <= 4'd0;
               end else if (w_low_hit) begin
                  r_state   <= ST_LOW;
                  r_low_cnt <= 4'd0;
                  batt_low  <= 1'b1;
               end else begin
                  r_low_cnt <= r_low_cnt + 4'd1;
               end
            end
            ST_LOW: begin
               // averages inside the hysteresis band also reset the count
               if (!w_above_exit) begin
                  r_low_cnt <= 4'd0;
               end else if (w_low_hit) begin
                  r_state   <= ST_OK;
                  r_low_cnt <= 4'd0;
                  batt_low  <= 1'b0;
               end else begin
                  r_low_cnt <= r_low_cnt + 4'd1;
               end
            end
            default: ;
         endcase
`ifdef BATT_MON_CRIT_EN
         // placed after the case so a CRIT entry overrides any OK/LOW move
         if (r_state != ST_CRIT) begin
            if (!w_below_crit) begin
               r_crit_cnt <= 4'd0;
            end else if (w_crit_hit) begin
               r_state    <= ST_CRIT;
               r_crit_cnt <= 4'd0;
               r_low_cnt  <= 4'd0;
               batt_low   <= 1'b1;
               batt_crit  <= 1'b1;
            end else begin
               r_crit_cnt <= r_crit_cnt + 4'd1;
            end
         end
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_batt_mon.sv
`default_nettype none
// ============================================================================
// Module   : tb_batt_mon
// Purpose  : Directed, table-driven self-checking bench for batt_mon
//            (default parameters; CRIT sequence only with BATT_MON_CRIT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_batt_mon;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        batt_vld = 1'b0;
   logic [11:0] batt = 12'h000;
   logic [11:0] batt_avg;
   logic        avg_rdy;
   logic        batt_low;
   logic        batt_crit;

   int n_pass  = 0;
   int n_total = 0;

   batt_mon dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .batt_vld (batt_vld),
      .batt     (batt),
      .batt_avg (batt_avg),
      .avg_rdy  (avg_rdy),
      .batt_low (batt_low),
      .batt_crit(batt_crit)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] batt;
      int          n_avg;
      logic [11:0] exp_avg;
      logic        exp_low;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // one strobe, captured at the next rising edge; returns 1 ns after it
   task automatic strobe(input logic [11:0] v);
      batt     = v;
      batt_vld = 1'b1;
      @(posedge clk);
      #1;
      batt_vld = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic feed_avg(input logic [11:0] v, input int n);
      repeat (n * 8) strobe(v);
      idle(2);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
   endtask

   initial begin
      int errs;
      int pulses;

      // from LOW: hysteresis band, exit boundary, then OK-side dwell checks
      tbl[0]  = '{12'h830, 10, 12'h830, 1'b1};
      tbl[1]  = '{12'h840,  3, 12'h840, 1'b1};
      tbl[2]  = '{12'h840,  1, 12'h840, 1'b0};
      tbl[3]  = '{12'h7F0,  3, 12'h7F0, 1'b0};
      tbl[4]  = '{12'h900,  1, 12'h900, 1'b0};
      tbl[5]  = '{12'h7F0,  3, 12'h7F0, 1'b0};
      tbl[6]  = '{12'h900,  1, 12'h900, 1'b0};
      tbl[7]  = '{12'h7FF,  3, 12'h7FF, 1'b0};
      tbl[8]  = '{12'h800,  1, 12'h800, 1'b0};
      tbl[9]  = '{12'h7FF,  3, 12'h7FF, 1'b0};
      tbl[10] = '{12'h7FF,  1, 12'h7FF, 1'b1};
      tbl[11] = '{12'h840,  3, 12'h840, 1'b1};
      tbl[12] = '{12'h83F,  1, 12'h83F, 1'b1};
      tbl[13] = '{12'h840,  3, 12'h840, 1'b1};
      tbl[14] = '{12'h840,  1, 12'h840, 1'b0};

      idle(2);
      chk("reset_avg", 32'(batt_avg), 32'hFFF);
      chk("reset_rdy", 32'(avg_rdy), 32'h0);
      chk("reset_low", 32'(batt_low), 32'h0);
      chk("reset_crit", 32'(batt_crit), 32'h0);
      rst_n = 1'b1;
      idle(1);

      // 64 full-scale strobes: pulse on every 8th, never low
      errs   = 0;
      pulses = 0;
      for (int i = 0; i < 64; i++) begin
         strobe(12'hFFF);
         if (avg_rdy !== ((i % 8) == 7)) errs++;
         if (avg_rdy === 1'b1) pulses++;
         if (batt_low !== 1'b0) errs++;
      end
      chk("full_pattern_errs", 32'(errs), 32'd0);
      chk("full_pulses", 32'(pulses), 32'd8);
      chk("full_avg", 32'(batt_avg), 32'hFFF);
      idle(2);

      // 7F0: low must rise exactly two cycles after the 32nd strobe
      errs = 0;
      for (int i = 0; i < 32; i++) begin
         strobe(12'h7F0);
         if (batt_low !== 1'b0) errs++;
      end
      chk("low_early", 32'(errs), 32'd0);
      chk("low_avg", 32'(batt_avg), 32'h7F0);
      chk("low_rdy", 32'(avg_rdy), 32'h1);
      idle(1);
      chk("low_rise", 32'(batt_low), 32'h1);
      idle(1);

      for (int k = 0; k < 15; k++) begin
         feed_avg(tbl[k].batt, tbl[k].n_avg);
         chk($sformatf("tbl%0d_avg", k), 32'(batt_avg), 32'(tbl[k].exp_avg));
         chk($sformatf("tbl%0d_low", k), 32'(batt_low), 32'(tbl[k].exp_low));
         chk($sformatf("tbl%0d_crit", k), 32'(batt_crit), 32'h0);
      end

      // truncating average with gaps where batt_vld is low and batt is junk
      for (int i = 0; i < 8; i++) begin
         strobe(12'h100 + 12'(i));
         batt = 12'hFFF;
         idle(1);
      end
      chk("trunc_avg", 32'(batt_avg), 32'h103);

      // asynchronous reset mid-accumulation discards the partial sum
      for (int i = 0; i < 5; i++) strobe(12'h000);
      #2 rst_n = 1'b0;
      #1;
      chk("async_avg", 32'(batt_avg), 32'hFFF);
      chk("async_low", 32'(batt_low), 32'h0);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      for (int i = 0; i < 7; i++) strobe(12'hFFF);
      chk("fresh_no_early_rdy", 32'(avg_rdy), 32'h0);
      strobe(12'hFFF);
      chk("fresh_rdy", 32'(avg_rdy), 32'h1);
      chk("fresh_avg", 32'(batt_avg), 32'hFFF);
      idle(2);

`ifdef BATT_MON_CRIT_EN
      do_reset();
      feed_avg(12'h6F0, 3);
      chk("crit_pre", 32'(batt_crit), 32'h0);
      chk("crit_pre_low", 32'(batt_low), 32'h0);
      feed_avg(12'h6F0, 1);
      chk("crit_set", 32'(batt_crit), 32'h1);
      chk("crit_low", 32'(batt_low), 32'h1);
      feed_avg(12'hFFF, 5);
      chk("crit_sticky", 32'(batt_crit), 32'h1);
      chk("crit_sticky_low", 32'(batt_low), 32'h1);
      do_reset();
      chk("crit_clr", 32'(batt_crit), 32'h0);
      chk("crit_clr_low", 32'(batt_low), 32'h0);
`else
      // without the CRIT build, deep averages only drive the LOW path
      do_reset();
      feed_avg(12'h6F0, 4);
      chk("nocrit_low", 32'(batt_low), 32'h1);
      chk("nocrit_crit", 32'(batt_crit), 32'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
